// File: rtl/rv_imm_pkg.sv
// Shared types for the immediate-decode stage: RV32I/Zicsr opcodes, immediate
// format codes and the decoder result record.
package rv_imm_pkg;

  localparam int MAX_XLEN = 64;

  typedef enum logic [6:0] {
    OPC_LUI      = 7'b0110111,
    OPC_AUIPC    = 7'b0010111,
    OPC_JAL      = 7'b1101111,
    OPC_JALR     = 7'b1100111,
    OPC_BRANCH   = 7'b1100011,
    OPC_LOAD     = 7'b0000011,
    OPC_STORE    = 7'b0100011,
    OPC_OP_IMM   = 7'b0010011,
    OPC_OP       = 7'b0110011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_SYSTEM   = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_CSR  = 3'd6
  } imm_fmt_t;

  // imm is always MAX_XLEN wide; bits above the stage XLEN are zero.
  typedef struct packed {
    logic [MAX_XLEN-1:0] imm;
    imm_fmt_t            fmt;
    logic                illegal;
  } decoded_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: one instruction word in, immediate value,
// format code and illegal flag out.
module imm_decode
  import rv_imm_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter bit ENABLE_CSR_IMM = 1'b1
) (
  input  logic [31:0] ir,
  output decoded_t    dec
);

  logic [MAX_XLEN-1:0] raw;
  imm_fmt_t            fmt;
  logic                illegal;

  // Every format is built at full width, then clipped to XLEN so that the
  // sign extension lands exactly on the stage width.
  always_comb begin
    raw     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    if (ir[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (opcode_t'(ir[6:0]))
        OPC_OP: ;
        OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
          fmt = FMT_I;
          raw = {{52{ir[31]}}, ir[31:20]};
        end
        OPC_STORE: begin
          fmt = FMT_S;
          raw = {{52{ir[31]}}, ir[31:25], ir[11:7]};
        end
        OPC_BRANCH: begin
          fmt = FMT_B;
          raw = {{51{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
        end
        OPC_LUI, OPC_AUIPC: begin
          fmt = FMT_U;
          raw = {{32{ir[31]}}, ir[31:12], 12'h000};
        end
        OPC_JAL: begin
          fmt = FMT_J;
          raw = {{43{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
        end
        OPC_SYSTEM: begin
          if (ENABLE_CSR_IMM && ir[14]) begin
            fmt = FMT_CSR;
            raw = {59'd0, ir[19:15]};
          end
        end
        OPC_MISC_MEM: ;
        default: illegal = 1'b1;
      endcase
    end
    if (XLEN == 32) begin
      raw[63:32] = '0;
    end
  end

  assign dec = '{imm: raw, fmt: fmt, illegal: illegal};

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage: decodes on the input side, precomputes
// pc + imm, and buffers up to two words behind a valid/ready skid buffer.
module imm_decode_stage
  import rv_imm_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter bit ENABLE_CSR_IMM = 1'b1,
  parameter int ILL_CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_ir,
  input  logic [XLEN-1:0]      in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_imm,
  output logic [2:0]           out_fmt,
  output logic [XLEN-1:0]      out_pc,
  output logic [XLEN-1:0]      out_target,
  output logic                 out_illegal,
  output logic [ILL_CNT_W-1:0] ill_count
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]      state;
  decoded_t        dec;
  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] dec_target;
  logic            skid_valid;
  logic            accept;
  logic            transfer;

  logic [XLEN-1:0] skid_imm;
  logic [2:0]      skid_fmt;
  logic [XLEN-1:0] skid_pc;
  logic [XLEN-1:0] skid_target;
  logic            skid_illegal;

  imm_decode #(
    .XLEN           (XLEN),
    .ENABLE_CSR_IMM (ENABLE_CSR_IMM)
  ) u_decode (
    .ir  (in_ir),
    .dec (dec)
  );

  assign dec_imm = dec.imm[XLEN-1:0];

  if (XLEN < MAX_XLEN) begin : g_imm_hi
    logic unused_imm_hi;
    assign unused_imm_hi = ^dec.imm[MAX_XLEN-1:XLEN];
  end

  assign dec_target = in_pc + dec_imm;

  assign skid_valid = (state == ST_FULL);
  assign in_ready   = ~skid_valid;
  assign out_valid  = (state != ST_EMPTY);
  assign accept     = in_valid & in_ready;
  assign transfer   = out_valid & out_ready;

  // The output register always holds the oldest word; the skid register only
  // fills when a word arrives while the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_EMPTY;
      out_imm      <= '0;
      out_fmt      <= FMT_NONE;
      out_pc       <= '0;
      out_target   <= '0;
      out_illegal  <= 1'b0;
      skid_imm     <= '0;
      skid_fmt     <= FMT_NONE;
      skid_pc      <= '0;
      skid_target  <= '0;
      skid_illegal <= 1'b0;
      ill_count    <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            out_imm     <= dec_imm;
            out_fmt     <= dec.fmt;
            out_pc      <= in_pc;
            out_target  <= dec_target;
            out_illegal <= dec.illegal;
            state       <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && transfer) begin
            out_imm     <= dec_imm;
            out_fmt     <= dec.fmt;
            out_pc      <= in_pc;
            out_target  <= dec_target;
            out_illegal <= dec.illegal;
          end else if (accept) begin
            skid_imm     <= dec_imm;
            skid_fmt     <= dec.fmt;
            skid_pc      <= in_pc;
            skid_target  <= dec_target;
            skid_illegal <= dec.illegal;
            state        <= ST_FULL;
          end else if (transfer) begin
            state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (transfer) begin
            out_imm     <= skid_imm;
            out_fmt     <= skid_fmt;
            out_pc      <= skid_pc;
            out_target  <= skid_target;
            out_illegal <= skid_illegal;
            state       <= ST_ONE;
          end
        end
        default: state <= ST_EMPTY;
      endcase

      if (accept && dec.illegal && (ill_count != '1)) begin
        ill_count <= ill_count + ILL_CNT_W'(1);
      end
    end
  end

endmodule
